// File: rtl/alu_issue_stage_if.sv
// Bundle of upstream issue, ALU drive/return and downstream result signals
// around the two-entry ALU issue stage.
interface alu_issue_stage_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   aluop;
  logic [2:0]   funct3;
  logic         funct7_5;
  logic         is_rtype;
  logic         alu_src;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic [N-1:0] imm;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_operation;
  logic [N-1:0] alu_res;
  logic         alu_zero;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;
  logic         out_zero;
  logic         out_illegal;

  // Stage side: consumes instructions and ALU results, produces ALU drive and results.
  modport slave (
    input  in_valid, aluop, funct3, funct7_5, is_rtype, alu_src,
           rs1_data, rs2_data, imm, alu_res, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_operation,
           out_valid, out_res, out_zero, out_illegal
  );

  modport master (
    output in_valid, aluop, funct3, funct7_5, is_rtype, alu_src,
           rs1_data, rs2_data, imm, alu_res, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_operation,
           out_valid, out_res, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-entry issue/capture stage: stage 1 decodes and registers ALU operands,
// stage 2 captures the ALU result, with valid/ready back-pressure and flush.
module alu_issue_stage #(
  parameter int N = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic         s1_illegal_q, s1_illegal_d;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_res_q, out_res_d;
  logic         out_zero_q, out_zero_d;
  logic         out_illegal_q, out_illegal_d;

  logic [3:0]   op_dec;
  logic         illegal_dec;
  logic [N-1:0] operand_b;
  logic         advance;
  logic         load_s2;
  logic         in_ready;
  logic         accept;

  always_comb begin
    op_dec      = OP_ADD;
    illegal_dec = 1'b0;
    case (bus.aluop)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  op_dec = (bus.is_rtype & bus.funct7_5) ? OP_SUB : OP_ADD;
          3'b111:  op_dec = OP_AND;
          3'b110:  op_dec = OP_OR;
          default: illegal_dec = 1'b1;
        endcase
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  assign operand_b = bus.alu_src ? bus.imm : bus.rs2_data;

  // A flush cycle neither accepts nor moves work into stage 2.
  assign advance  = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign load_s2  = advance & ~flush;
  assign in_ready = ~flush & (~s1_valid_q | advance);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    s1_illegal_d = s1_illegal_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d   = 1'b1;
      alu_a_d      = bus.rs1_data;
      alu_b_d      = operand_b;
      alu_op_d     = op_dec;
      s1_illegal_d = illegal_dec;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_res_d     = out_res_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_s2) begin
      out_valid_d   = 1'b1;
      out_res_d     = bus.alu_res;
      out_zero_d    = bus.alu_zero;
      out_illegal_d = s1_illegal_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      s1_illegal_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      s1_illegal_q  <= s1_illegal_d;
      out_valid_q   <= out_valid_d;
      out_res_q     <= out_res_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_operation = alu_op_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_res       = out_res_q;
  assign bus.out_zero      = out_zero_q;
  assign bus.out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural 64-bit ALU closing the loop.
module tb_alu_issue_stage;

  localparam int N = 64;

  typedef struct {
    logic [N-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_chk;
  int   n_fail;
  int   cyc;
  exp_t sb[$];
  int   pop_cyc[$];

  alu_issue_stage_if #(.N(N)) ifc ();

  alu_issue_stage #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (ifc.alu_operation)
      4'd0:    ifc.alu_res = ifc.alu_a & ifc.alu_b;
      4'd1:    ifc.alu_res = ifc.alu_a | ifc.alu_b;
      4'd2:    ifc.alu_res = ifc.alu_a + ifc.alu_b;
      4'd6:    ifc.alu_res = ifc.alu_a - ifc.alu_b;
      default: ifc.alu_res = '0;
    endcase
    ifc.alu_zero = (ifc.alu_res == '0);
  end

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_res", ifc.out_res, e.res);
        chk("sb_zero", N'(ifc.out_zero), N'(e.zero));
        chk("sb_illegal", N'(ifc.out_illegal), N'(e.ill));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic rt, input logic src,
                      input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] im,
                      input logic [N-1:0] er, input logic ez, input logic ei);
    int n;
    exp_t e;
    ifc.aluop    = op;
    ifc.funct3   = f3;
    ifc.funct7_5 = f75;
    ifc.is_rtype = rt;
    ifc.alu_src  = src;
    ifc.rs1_data = a;
    ifc.rs2_data = b;
    ifc.imm      = im;
    ifc.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      chk("send_timeout", 0, 1);
      ifc.in_valid = 1'b0;
    end else begin
      e.res  = er;
      e.zero = ez;
      e.ill  = ei;
      sb.push_back(e);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] ones;
    int k;
    ones = '1;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; flush = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    ifc.aluop = '0; ifc.funct3 = '0; ifc.funct7_5 = 1'b0; ifc.is_rtype = 1'b0;
    ifc.alu_src = 1'b0; ifc.rs1_data = '0; ifc.rs2_data = '0; ifc.imm = '0;

    #12;
    chk("rst_out_valid", N'(ifc.out_valid), 0);
    chk("rst_in_ready", N'(ifc.in_ready), 1);
    chk("rst_alu_op", N'(ifc.alu_operation), 0);
    chk("rst_alu_a", ifc.alu_a, 0);
    chk("rst_out_res", ifc.out_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Single ADD: latency check around edges E and E+1
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd5, 64'd0, 64'd7, 64'd12, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_not_yet", N'(ifc.out_valid), 0);
    chk("add_alu_op", N'(ifc.alu_operation), 2);
    @(negedge clk);
    chk("add_valid", N'(ifc.out_valid), 1);
    chk("add_res", ifc.out_res, 64'd12);
    chk("add_zero", N'(ifc.out_zero), 0);
    idle(2);

    // R-type sweep back-to-back
    k = pop_cyc.size();
    send(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 64'hF0, 64'h3C, 64'd0, 64'hB4,  1'b0, 1'b0);
    send(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 64'hF0, 64'h3C, 64'd0, 64'h30,  1'b0, 1'b0);
    send(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 64'hF0, 64'h3C, 64'd0, 64'hFC,  1'b0, 1'b0);
    send(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 64'hF0, 64'h3C, 64'd0, 64'h12C, 1'b0, 1'b0);
    idle(4);
    chk("sweep_count", N'(pop_cyc.size() - k), 4);
    if (pop_cyc.size() - k == 4)
      for (int i = 1; i < 4; i++)
        chk("sweep_consecutive", N'(pop_cyc[k+i] - pop_cyc[k+i-1]), 1);

    // Branch compares
    send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0);
    send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h1235, 64'd0, ones, 1'b0, 1'b0);
    idle(3);

    // Back-pressure with four ADDs
    ifc.out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd100, 64'd0, 64'd1, 64'd101, 1'b0, 1'b0);
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd200, 64'd0, 64'd2, 64'd202, 1'b0, 1'b0);
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", N'(ifc.in_ready), 0);
      chk("bp_out_valid", N'(ifc.out_valid), 1);
      chk("bp_out_held", ifc.out_res, 64'd101);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd300, 64'd0, 64'd3, 64'd303, 1'b0, 1'b0);
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd400, 64'd0, 64'd4, 64'd404, 1'b0, 1'b0);
    idle(4);
    chk("bp_drained", N'(sb.size()), 0);

    // Illegal encodings
    send(2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 64'd10, 64'd0, 64'd3, 64'd13, 1'b0, 1'b1);
    send(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 64'h100, 64'h23, 64'd0, 64'h123, 1'b0, 1'b1);
    idle(4);

    // Flush with both stages full and a simultaneous offer
    ifc.out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd1, 64'd0, 64'd1, 64'd2, 1'b0, 1'b0);
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 64'd3, 64'd0, 64'd3, 64'd6, 1'b0, 1'b0);
    flush = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.rs1_data = 64'd77;
    @(negedge clk);
    chk("flush_in_ready", N'(ifc.in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", N'(ifc.out_valid), 0);
    chk("flush_s1_empty", N'(ifc.in_ready), 1);
    idle(2);
    chk("flush_still_empty", N'(ifc.out_valid), 0);

    // Refill, then asynchronous reset mid-cycle
    send(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 64'hA0, 64'h0B, 64'd0, 64'hAB, 1'b0, 1'b0);
    send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'd9, 64'd4, 64'd0, 64'd5, 1'b0, 1'b0);
    #2;
    chk("pre_rst_full", N'(ifc.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", N'(ifc.out_valid), 0);
    chk("arst_out_res", ifc.out_res, 0);
    chk("arst_alu_op", N'(ifc.alu_operation), 0);
    chk("arst_in_ready", N'(ifc.in_ready), 1);
    sb.delete();
    ifc.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd40, 64'd2, 64'd0, 64'd42, 1'b0, 1'b0);
    idle(3);
    chk("final_drained", N'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-entry pipelined issue/capture stage wrapped around the 64-bit combinational `alu`. Stage 1 decodes the main-control `aluop` and instruction `funct` fields into the 4-bit `operation` code, selects the second operand, and registers operands and opcode to drive the ALU. Stage 2 captures the ALU `res`/`zero` into an output register. A valid/ready handshake on both sides allows back-pressure from the memory stage, and a flush clears in-flight work.

## Interface
- `N`, 64, datapath width; must equal the `alu` width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of both stages.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `aluop`  in  2  from main control: 00 load/store, 01 branch, 10 R/I-type, 11 reserved.
- `funct3`  in  3  instruction funct3.
- `funct7_5`  in  1  instruction bit 30.
- `is_rtype`  in  1  1 = register-register form (enables SUB via funct7_5).
- `alu_src`  in  1  1 = use `imm` as operand B, 0 = use `rs2_data`.
- `rs1_data`, `rs2_data`, `imm`  in  N each  operands.
- `alu_a`, `alu_b`  out  N  registered stage-1 operands to the ALU.
- `alu_operation`  out  4  registered opcode to the ALU.
- `alu_res`  in  N  ALU result (combinational from `alu_*`).
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  stage-2 holds a result.
- `out_ready`  in  1  downstream accepts.
- `out_res`  out  N  registered result.
- `out_zero`  out  1  registered zero flag.
- `out_illegal`  out  1  registered illegal-encoding flag.

## Operation
- Decode rules:
  - `aluop` 00 → 2 (ADD).
  - `aluop` 01 → 6 (SUB).
  - `aluop` 10 with funct3 000 → 6 if `is_rtype & funct7_5`, else 2.
  - `aluop` 10 with funct3 111 → 0 (AND).
  - `aluop` 10 with funct3 110 → 1 (OR).
  - Any other `aluop` 10 funct3, or `aluop` 11 → 2, with the illegal bit set.
- Operand B = `alu_src ? imm : rs2_data`. Operand A = `rs1_data`. No width extension is done here; upstream supplies full N-bit values.
- Stage 1 register (`s1_valid`, `alu_a`, `alu_b`, `alu_operation`, `s1_illegal`) loads on `in_valid & in_ready`.
- Advance condition: `s1_valid & (!out_valid | out_ready)`.
- On advance, stage 2 (`out_valid`, `out_res`, `out_zero`, `out_illegal`) loads from `alu_res`, `alu_zero` and `s1_illegal`.
- `in_ready = !flush & (!s1_valid | advance)`. This is a combinational path from `out_ready`; that path is accepted.
- `s1_valid` next: 1 if a new input is accepted; else 0 if stage 1 advanced; else hold.
- `out_valid` next: 1 on advance; else 0 if `out_ready`; else hold.
- While `out_valid & !out_ready`, all `out_*` are held stable. Stage 1 is also held once it is full.
- Flush: on the next edge `s1_valid` and `out_valid` are 0. Data registers may keep stale values. In a flush cycle no input is accepted (`in_ready` = 0) and stage 2 does not load.

## Timing
- Reset (async assert, sync release) drives every register to 0: `out_valid`, `out_res`, `out_zero`, `out_illegal`, `alu_a`, `alu_b`, `alu_operation`, and `s1_valid`.
  - Consequence: `in_ready` = 1 immediately after reset, and `alu_operation` resets to 0 (AND).
- Latency: an input accepted at edge E drives the ALU from E. Its result appears on `out_*` with `out_valid` = 1 after edge E+1.
- Throughput is 1 per cycle with `out_ready` held high.
- Full stall: both stages valid and `out_ready` = 0 forces `in_ready` = 0. When `out_ready` rises, stage 1 advances and a new input is accepted in the same cycle; no bubble is inserted.
- Reset asserted mid-operation discards both entries immediately. No output transaction completes afterwards.
- Flush and `out_ready` in the same cycle: the held output is considered consumed, and `out_valid` is still 0 next cycle.

## Test plan
- Reset then single ADD: `aluop`=00, `rs1`=5, `imm`=7, `alu_src`=1 → two cycles later `out_valid`=1, `out_res`=12, `out_zero`=0, `out_illegal`=0.
- R-type decode sweep: `rs1`=0xF0, `rs2`=0x3C, `is_rtype`=1 →
  - funct3 000, funct7_5=1 (SUB): `out_res`=0xB4.
  - funct3 111 (AND): 0x30.
  - funct3 110 (OR): 0xFC.
  - funct3 000, funct7_5=0 (ADD): 0x12C.
  - Back-to-back with `out_ready`=1, so results arrive on consecutive cycles.
- Branch compare: `aluop`=01, `rs1`=`rs2`=0x1234 → `out_res`=0, `out_zero`=1. With `rs2`=0x1235 → `out_res`=all-ones, `out_zero`=0.
- Back-pressure: stream 4 ADDs with `out_ready`=0 for 3 cycles. Expect `in_ready`=0 after 2 accepts and `out_res` stable while held. Then raise `out_ready`: all 4 results come out in order with no loss or duplication.
- Illegal encoding: `aluop`=11, then `aluop`=10 with funct3=100 → `out_illegal`=1 and `out_res`=`rs1`+B on both.
- Flush and async reset: with both stages full, pulse `flush` together with `in_valid` → `out_valid`=0 next cycle and that input is not accepted (`in_ready`=0). Refill both stages, then assert `rst_n`=0 mid-cycle → `out_valid`, `out_res` and `alu_operation` read 0 before the next edge.
